// File: rtl/command_vars.sv
// Shared command, op and status encodings for the SPI-NAND op sequencer.
package command_vars;

    // Controller command set, extended with the NAND array operations.
    typedef enum logic [3:0] {
        WRITE_ENABLE     = 4'h0,
        WRITE_DISABLE    = 4'h1,
        GET_FEATURE      = 4'h2,
        SET_FEATURE      = 4'h3,
        PAGE_READ        = 4'h4,
        CACHE_READ       = 4'h5,
        PROG_LOAD1       = 4'h6,
        PROG_LOAD_RANDOM = 4'h7,
        PROG_EXEC        = 4'h8,
        BLOCK_ERASE      = 4'h9,
        READ_ID          = 4'hA,
        RESET_CMD        = 4'hB
    } SPI_Command;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_PROGRAM = 2'd1;
    localparam logic [1:0] OP_ERASE   = 2'd2;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_PFAIL   = 3'd1;
    localparam logic [2:0] ST_EFAIL   = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_BADOP   = 3'd4;

    localparam logic [7:0] FEAT_STATUS_ADDR = 8'hC0;
    localparam int OIP    = 0;
    localparam int E_FAIL = 2;
    localparam int P_FAIL = 3;

    // GET_FEATURE carries the feature address in bits [15:8].
    function automatic logic [23:0] feat_addr();
        return {8'h00, FEAT_STATUS_ADDR, 8'h00};
    endfunction

endpackage

// File: rtl/cm_issue.sv
// Command handshake engine: one DV pulse per command, wait for the controller
// to go busy (with timeout), then wait for it to return ready.
module cm_issue
    import command_vars::*;
#(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  SPI_Command  cmd_i,
    input  logic [23:0] addr_i,
    input  logic        cm_ready_i,
    output logic        fire_o,
    output logic        done_o,
    output logic        tmo_o,
    output SPI_Command  cmd_o,
    output logic        dv_o,
    output logic [23:0] addr_o
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [1:0] E_IDLE = 2'd0;
    localparam logic [1:0] E_ACK  = 2'd1;
    localparam logic [1:0] E_DONE = 2'd2;

    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dv_q;
    SPI_Command       cmd_q;
    logic [23:0]      addr_q;

    // Idle engine with a pending start is the issue point; DV only when controller is ready.
    assign fire_o = (st_q == E_IDLE) && start_i && cm_ready_i;
    assign tmo_o  = (st_q == E_ACK) && cm_ready_i && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    assign done_o = (st_q == E_DONE) && cm_ready_i;
    assign dv_o   = dv_q;
    assign cmd_o  = cmd_q;
    assign addr_o = addr_q;

    // Next-state for the handshake phases.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            E_IDLE: if (fire_o) begin st_d = E_ACK; cnt_d = '0; end
            E_ACK: begin
                if (!cm_ready_i)  st_d = E_DONE;
                else if (tmo_o)   st_d = E_IDLE;
                else              cnt_d = cnt_q + 1'b1;
            end
            E_DONE: if (cm_ready_i) st_d = E_IDLE;
            default: st_d = E_IDLE;
        endcase
    end

    // Command/address latch at the DV cycle and hold until the next issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q   <= E_IDLE;
            cnt_q  <= '0;
            dv_q   <= 1'b0;
            cmd_q  <= WRITE_ENABLE;
            addr_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            dv_q  <= fire_o;
            if (fire_o) begin
                cmd_q  <= cmd_i;
                addr_q <= addr_i;
            end
        end
    end

endmodule

// File: rtl/nand_op_sequencer.sv
// Sequences READ / PROGRAM / ERASE command chains and status polling on top
// of the SPI memory command controller.
module nand_op_sequencer
    import command_vars::*;
#(
    parameter int POLL_GAP    = 16,
    parameter int MAX_POLLS   = 4096,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Op_Valid,
    input  logic [1:0]  i_Op,
    input  logic [23:0] i_Row_Addr,
    input  logic [12:0] i_Col_Addr,
    output logic        o_Op_Ready,
    output logic        o_Done,
    output logic [2:0]  o_Status,
    output logic [7:0]  o_Status_Byte,
    output SPI_Command  o_Command,
    output logic        o_CM_DV,
    output logic [23:0] o_Addr_Data,
    input  logic        i_CM_Ready,
    input  logic [7:0]  i_RX_Feature_Byte,
    input  logic        i_RX_Feature_DV
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;  // issue a chain step or a poll
    localparam logic [2:0] S_EXEC   = 3'd2;  // chain command in flight
    localparam logic [2:0] S_POLL   = 3'd3;  // GET_FEATURE in flight, capture byte
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]  st_q, st_d;
    logic [1:0]  op_q, op_d, step_q, step_d;
    logic [23:0] row_q, row_d;
    logic [12:0] col_q, col_d;
    logic        poll_q, poll_d, seen_q, seen_d;
    logic [12:0] pcnt_q, pcnt_d, pcnt_nx;
    logic [15:0] gap_q, gap_d;
    logic [2:0]  status_q, status_d;
    logic [7:0]  sbyte_q, sbyte_d;

    SPI_Command  cmd;
    logic [23:0] addr;
    logic        fire, cm_done, cm_tmo;
    logic        accept, fb_dv, oip, chain_polls;
    logic [7:0]  byte_now;

    assign o_Op_Ready    = (st_q == S_IDLE) || (st_q == S_FINISH);
    assign o_Done        = (st_q == S_FINISH);
    assign o_Status      = status_q;
    assign o_Status_Byte = sbyte_q;
    assign accept        = i_Op_Valid && o_Op_Ready;

    // A missing feature byte for a poll counts as "still busy".
    assign fb_dv    = i_RX_Feature_DV && (st_q == S_POLL);
    assign byte_now = fb_dv ? i_RX_Feature_Byte : sbyte_q;
    assign oip      = !(fb_dv || seen_q) || byte_now[OIP];
    assign pcnt_nx  = (pcnt_q == 13'h1FFF) ? pcnt_q : pcnt_q + 13'd1;
    assign chain_polls = (op_q == OP_READ    && step_q == 2'd0) ||
                         (op_q == OP_PROGRAM && step_q == 2'd2) ||
                         (op_q == OP_ERASE   && step_q == 2'd1);

    // Command and address for the current chain step or poll.
    always_comb begin
        cmd  = WRITE_ENABLE;
        addr = '0;
        if (poll_q) begin
            cmd  = GET_FEATURE;
            addr = feat_addr();
        end else begin
            case (op_q)
                OP_READ: begin
                    if (step_q == 2'd0) begin cmd = PAGE_READ;  addr = row_q; end
                    else                begin cmd = CACHE_READ; addr = {11'd0, col_q}; end
                end
                OP_PROGRAM: begin
                    if (step_q == 2'd1)      begin cmd = PROG_LOAD1; addr = {11'd0, col_q}; end
                    else if (step_q == 2'd2) begin cmd = PROG_EXEC;  addr = row_q; end
                end
                default: if (step_q != 2'd0) begin cmd = BLOCK_ERASE; addr = row_q; end
            endcase
        end
    end

    // Sequencer next-state: op accept, chain stepping, poll evaluation.
    always_comb begin
        st_d = st_q; op_d = op_q; step_d = step_q; row_d = row_q; col_d = col_q;
        poll_d = poll_q; seen_d = seen_q; pcnt_d = pcnt_q; gap_d = gap_q;
        status_d = status_q; sbyte_d = sbyte_q;
        case (st_q)
            S_IDLE, S_FINISH: begin
                if (st_q == S_FINISH) st_d = S_IDLE;
                if (accept) begin
                    op_d = i_Op; row_d = i_Row_Addr; col_d = i_Col_Addr;
                    step_d = 2'd0; poll_d = 1'b0; pcnt_d = '0;
                    if (i_Op == 2'd3) begin st_d = S_FINISH; status_d = ST_BADOP; end
                    else              st_d = S_CMD;
                end
            end
            S_CMD: if (fire) begin
                st_d = poll_q ? S_POLL : S_EXEC;
                seen_d = 1'b0;
            end
            S_EXEC: begin
                if (cm_tmo) begin st_d = S_FINISH; status_d = ST_TIMEOUT; end
                else if (cm_done) begin
                    if (chain_polls)          begin poll_d = 1'b1; st_d = S_CMD; end
                    else if (op_q == OP_READ) begin st_d = S_FINISH; status_d = ST_OK; end
                    else                      begin step_d = step_q + 2'd1; st_d = S_CMD; end
                end
            end
            S_POLL: begin
                if (fb_dv) begin sbyte_d = i_RX_Feature_Byte; seen_d = 1'b1; end
                if (cm_tmo) begin st_d = S_FINISH; status_d = ST_TIMEOUT; end
                else if (cm_done) begin
                    pcnt_d = pcnt_nx;
                    if (oip) begin
                        if (int'(pcnt_nx) >= MAX_POLLS) begin st_d = S_FINISH; status_d = ST_TIMEOUT; end
                        else if (POLL_GAP == 0)         st_d = S_CMD;
                        else                            begin st_d = S_GAP; gap_d = '0; end
                    end else begin
                        poll_d = 1'b0;
                        st_d = S_FINISH;
                        status_d = ST_OK;
                        if (op_q == OP_PROGRAM && byte_now[P_FAIL])    status_d = ST_PFAIL;
                        else if (op_q == OP_ERASE && byte_now[E_FAIL]) status_d = ST_EFAIL;
                        else if (op_q == OP_READ) begin step_d = 2'd1; st_d = S_CMD; end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 16'(POLL_GAP - 1)) st_d = S_CMD;
                else                            gap_d = gap_q + 16'd1;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            st_q <= S_IDLE; op_q <= '0; step_q <= '0; row_q <= '0; col_q <= '0;
            poll_q <= 1'b0; seen_q <= 1'b0; pcnt_q <= '0; gap_q <= '0;
            status_q <= ST_OK; sbyte_q <= '0;
        end else begin
            st_q <= st_d; op_q <= op_d; step_q <= step_d; row_q <= row_d; col_q <= col_d;
            poll_q <= poll_d; seen_q <= seen_d; pcnt_q <= pcnt_d; gap_q <= gap_d;
            status_q <= status_d; sbyte_q <= sbyte_d;
        end
    end

    cm_issue #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_issue (
        .clk_i      (i_Clk),
        .rst_i      (i_Rst),
        .start_i    (st_q == S_CMD),
        .cmd_i      (cmd),
        .addr_i     (addr),
        .cm_ready_i (i_CM_Ready),
        .fire_o     (fire),
        .done_o     (cm_done),
        .tmo_o      (cm_tmo),
        .cmd_o      (o_Command),
        .dv_o       (o_CM_DV),
        .addr_o     (o_Addr_Data)
    );

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Scoreboard bench for nand_op_sequencer with a simple controller model.
module tb_nand_op_sequencer;
    import command_vars::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_Op_Valid = 1'b0;
    logic [1:0]  i_Op = '0;
    logic [23:0] i_Row_Addr = '0;
    logic [12:0] i_Col_Addr = '0;
    logic        o_Op_Ready, o_Done, o_CM_DV;
    logic [2:0]  o_Status;
    logic [7:0]  o_Status_Byte;
    SPI_Command  o_Command;
    logic [23:0] o_Addr_Data;
    logic        i_CM_Ready = 1'b1;
    logic [7:0]  i_RX_Feature_Byte = '0;
    logic        i_RX_Feature_DV = 1'b0;

    always #5 clk = ~clk;

    nand_op_sequencer #(.POLL_GAP(2), .MAX_POLLS(4), .ACK_TIMEOUT(64)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Op_Valid(i_Op_Valid), .i_Op(i_Op),
        .i_Row_Addr(i_Row_Addr), .i_Col_Addr(i_Col_Addr), .o_Op_Ready(o_Op_Ready),
        .o_Done(o_Done), .o_Status(o_Status), .o_Status_Byte(o_Status_Byte),
        .o_Command(o_Command), .o_CM_DV(o_CM_DV), .o_Addr_Data(o_Addr_Data),
        .i_CM_Ready(i_CM_Ready), .i_RX_Feature_Byte(i_RX_Feature_Byte),
        .i_RX_Feature_DV(i_RX_Feature_DV)
    );

    typedef struct { SPI_Command cmd; logic [23:0] addr; } cmd_t;
    typedef struct { logic [2:0] st; logic [7:0] sb; } done_t;

    cmd_t       exp_cmd_q[$];
    done_t      exp_done_q[$];
    logic [7:0] feat_q[$];
    cmd_t       mon_c;
    done_t      mon_d;
    SPI_Command mdl_cmd;
    int n_vec = 0, n_fail = 0, cyc = 0, dv_count = 0, last_dv_cyc = 0, last_done_cyc = 0;
    bit ack_never = 0, inject_ff = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input SPI_Command c, input logic [23:0] a);
        cmd_t e;
        e.cmd = c; e.addr = a;
        exp_cmd_q.push_back(e);
    endtask

    task automatic push_done(input logic [2:0] st, input logic [7:0] sb);
        done_t e;
        e.st = st; e.sb = sb;
        exp_done_q.push_back(e);
    endtask

    // Monitor: every DV and every done pulse pops the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_CM_DV) begin
                dv_count++;
                last_dv_cyc = cyc;
                if (exp_cmd_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_cmd: got cmd %0h addr %0h, expected none", o_Command, o_Addr_Data);
                end else begin
                    mon_c = exp_cmd_q.pop_front();
                    chk("cmd", 32'(o_Command), 32'(mon_c.cmd));
                    chk("cmd_addr", 32'(o_Addr_Data), 32'(mon_c.addr));
                end
            end
            if (o_Done) begin
                last_done_cyc = cyc;
                if (exp_done_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_done: got status %0h, expected none", o_Status);
                end else begin
                    mon_d = exp_done_q.pop_front();
                    chk("done_status", 32'(o_Status), 32'(mon_d.st));
                    chk("done_status_byte", 32'(o_Status_Byte), 32'(mon_d.sb));
                end
            end
        end
    end

    // Controller model: busy 3 cycles per command; GET_FEATURE returns a byte
    // one cycle before ready comes back.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && o_CM_DV && !ack_never) begin
                mdl_cmd = o_Command;
                i_CM_Ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (inject_ff && mdl_cmd != GET_FEATURE) begin
                        i_RX_Feature_Byte = 8'hFF; i_RX_Feature_DV = 1'b1;
                    end else i_RX_Feature_DV = 1'b0;
                end
                if (mdl_cmd == GET_FEATURE) begin
                    i_RX_Feature_Byte = (feat_q.size() != 0) ? feat_q.pop_front() : 8'h01;
                    i_RX_Feature_DV = 1'b1;
                    @(negedge clk);
                end
                i_RX_Feature_DV = 1'b0;
                i_CM_Ready = 1'b1;
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [23:0] row, input logic [12:0] col);
        int t = 0;
        while (!o_Op_Ready && t < 2000) begin @(negedge clk); t++; end
        i_Op = op; i_Row_Addr = row; i_Col_Addr = col; i_Op_Valid = 1'b1;
        @(negedge clk);
        i_Op_Valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!o_Done && t < 3000) begin @(negedge clk); t++; end
        if (!o_Done) begin
            n_vec++; n_fail++;
            $display("FAIL op_timeout: got no o_Done, expected one within 3000 cycles");
        end
        #1;
    endtask

    initial begin
        int t;
        int base;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_op_ready", 32'(o_Op_Ready), 32'd1);
        chk("rst_done", 32'(o_Done), 32'd0);
        chk("rst_status", 32'(o_Status), 32'(ST_OK));
        chk("rst_status_byte", 32'(o_Status_Byte), 32'h0);
        chk("rst_cm_dv", 32'(o_CM_DV), 32'd0);
        chk("rst_addr", 32'(o_Addr_Data), 32'h0);
        chk("rst_command", 32'(o_Command), 32'(WRITE_ENABLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // PROGRAM, OIP clears on the fourth poll
        push_cmd(WRITE_ENABLE, 24'h0); push_cmd(PROG_LOAD1, 24'h000034); push_cmd(PROG_EXEC, 24'h000040);
        repeat (4) push_cmd(GET_FEATURE, 24'h00C000);
        push_done(ST_OK, 8'h00);
        feat_q.push_back(8'h01); feat_q.push_back(8'h01); feat_q.push_back(8'h01); feat_q.push_back(8'h00);
        start_op(OP_PROGRAM, 24'h000040, 13'h034); wait_done();

        // ERASE failing
        push_cmd(WRITE_ENABLE, 24'h0); push_cmd(BLOCK_ERASE, 24'h000100); push_cmd(GET_FEATURE, 24'h00C000);
        push_done(ST_EFAIL, 8'h04);
        feat_q.push_back(8'h04);
        start_op(OP_ERASE, 24'h000100, 13'h0); wait_done();

        // PROGRAM failing
        push_cmd(WRITE_ENABLE, 24'h0); push_cmd(PROG_LOAD1, 24'h000000); push_cmd(PROG_EXEC, 24'h000200);
        push_cmd(GET_FEATURE, 24'h00C000);
        push_done(ST_PFAIL, 8'h08);
        feat_q.push_back(8'h08);
        start_op(OP_PROGRAM, 24'h000200, 13'h000); wait_done();

        // READ with a stray op request and stray feature bytes while busy
        push_cmd(PAGE_READ, 24'h000040); push_cmd(GET_FEATURE, 24'h00C000); push_cmd(CACHE_READ, 24'h000834);
        push_done(ST_OK, 8'h00);
        feat_q.push_back(8'h00);
        inject_ff = 1;
        start_op(OP_READ, 24'h000040, 13'h834);
        repeat (4) @(negedge clk);
        i_Op = OP_ERASE; i_Op_Valid = 1'b1;
        @(negedge clk);
        i_Op_Valid = 1'b0;
        wait_done();
        inject_ff = 0;

        // OIP stuck: MAX_POLLS polls then timeout
        push_cmd(PAGE_READ, 24'h000005);
        repeat (4) push_cmd(GET_FEATURE, 24'h00C000);
        push_done(ST_TIMEOUT, 8'h01);
        start_op(OP_READ, 24'h000005, 13'h0); wait_done();

        // Controller never acknowledges
        ack_never = 1;
        push_cmd(WRITE_ENABLE, 24'h0);
        push_done(ST_TIMEOUT, 8'h01);
        start_op(OP_ERASE, 24'h000007, 13'h0); wait_done();
        chk("ack_timeout_cycles", 32'(last_done_cyc - last_dv_cyc), 32'd64);
        ack_never = 0;

        // Reserved op
        push_done(ST_BADOP, 8'h01);
        start_op(2'd3, 24'h0, 13'h0); wait_done();

        // Reset during PROG_EXEC busy wait
        base = dv_count;
        push_cmd(WRITE_ENABLE, 24'h0); push_cmd(PROG_LOAD1, 24'h000010); push_cmd(PROG_EXEC, 24'h000300);
        start_op(OP_PROGRAM, 24'h000300, 13'h010);
        t = 0;
        while (dv_count < base + 3 && t < 500) begin @(negedge clk); t++; end
        chk("reached_prog_exec", 32'(dv_count - base), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_op_ready", 32'(o_Op_Ready), 32'd1);
        chk("midrst_cm_dv", 32'(o_CM_DV), 32'd0);
        chk("midrst_done", 32'(o_Done), 32'd0);
        chk("midrst_status_byte", 32'(o_Status_Byte), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        push_cmd(PAGE_READ, 24'h000040); push_cmd(GET_FEATURE, 24'h00C000); push_cmd(CACHE_READ, 24'h000834);
        push_done(ST_OK, 8'h00);
        feat_q.push_back(8'h00);
        start_op(OP_READ, 24'h000040, 13'h834); wait_done();

        repeat (10) @(negedge clk);
        chk("cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
